sm_in_cond: RTL and testbench
=============================

Name: sm_in_cond

Overview:
- Input conditioner placed directly upstream of the two-input FSM (inputs i1/i2; outputs o1/o2/err).
- Takes raw, asynchronous, possibly bouncing i1/i2 sources and delivers synchronized, debounced, glitch-free levels on the FSM clock.
- Also flags when the conditioned inputs are settled after reset, so the FSM's err logic does not see start-up transients.

Parameters:
- SYNC_STAGES, 2: synchronizer flops per channel; legal range >= 2.
- DB_CYCLES, 4: consecutive clocks a changed synced level must persist before the output follows; legal range >= 1 (1 = no filtering).
- RST_VAL, 2'b00: reset level of {i2,i1}, applied to the synchronizer chain and the outputs.

Ports:
- clk  input  1  rising-edge clock shared with the FSM.
- rst  input  1  synchronous, active-high reset.
- raw_i1  input  1  asynchronous raw source for channel 1.
- raw_i2  input  1  asynchronous raw source for channel 2.
- i1  output  1  conditioned channel 1; drives FSM i1.
- i2  output  1  conditioned channel 2; drives FSM i2.
- settled  output  1  high once post-reset settling has elapsed; sticky until the next rst.

Behaviour:
- Reset (rst high at a rising edge):
  - synchronizer flops <= RST_VAL bits; i1/i2 <= RST_VAL bits.
  - debounce counters <= 0; channel states <= ST_STABLE.
  - settled <= 0; settle counter <= 0.
- rst mid-debounce discards the pending change; the output stays at RST_VAL.
- Synchronizer: per channel, a SYNC_STAGES-deep flop chain. syn = last stage.
- Per-channel FSM, channels fully independent:
  - ST_STABLE: if syn == out, stay with cnt = 0. If syn != out:
    - DB_CYCLES == 1: out <= syn this edge; stay in ST_STABLE.
    - otherwise cnt <= 1; go to ST_CHANGING.
  - ST_CHANGING:
    - syn == out (glitch ended): cnt <= 0; go to ST_STABLE; out unchanged.
    - syn != out and cnt == DB_CYCLES-1: out <= ~out; cnt <= 0; go to ST_STABLE.
    - otherwise cnt <= cnt + 1.
- Latency: take the edge that first captures a new raw level as edge 1. The output changes at edge SYNC_STAGES+DB_CYCLES. Defaults: edge 6, i.e. 5 clocks after capture.
- Glitch rule: a synced pulse shorter than DB_CYCLES clocks never reaches the output.
- Counter width: CNT_W = clog2(DB_CYCLES+1), minimum 1. The counter never exceeds DB_CYCLES-1, so it does not wrap.
- settled:
  - The settle counter increments every non-reset edge.
  - settled <= 1 on the edge where the count reaches SYNC_STAGES+DB_CYCLES; the counter then saturates.
  - i1/i2 are valid regardless of settled; settled is only a qualifier for downstream err use.
- Simultaneous changes on raw_i1 and raw_i2 are filtered independently; no cross-channel coupling.

Optional Feature:
- Macro SM_IN_COND_EDGE_EN.
- Defined:
  - adds outputs i1_rise, i1_fall, i2_rise, i2_fall (1 bit each).
  - Each is a one-clock pulse, high during the first cycle its output shows the new level.
  - Pulses are forced 0 during reset and while settled == 0.
- Undefined: these ports and their logic do not exist; the remaining behaviour is identical.

Decomposition:
- Shared header sm_in_defs.vh holds:
  - state encodings ST_STABLE = 1'b0, ST_CHANGING = 1'b1.
  - N_CH = 2.
  - a clog2 constant function for CNT_W.
- Sub-module sm_in_chan: one synchronizer + debounce FSM + optional edge detect, parameterized by SYNC_STAGES, DB_CYCLES and its reset bit. Instantiated twice in sm_in_cond; settled logic lives at top level.

Test Plan:
- Reset: rst high 2 clocks with raw = 2'b11 -> i1=i2=0 and settled=0 during reset. After release, settled=1 exactly at the 6th post-reset edge. i1/i2 reach 1 at edge 6 after raw is first captured.
- Clean step: raw_i1 0->1 held 10 clocks (20ns clock, defaults) -> i1 rises 5 clocks after the capture edge; i2 unchanged.
- Glitch: raw_i2 high for exactly 3 synced clocks, then low -> i2 stays 0, counter returns to 0. A 4-clock pulse -> i2 rises for exactly 4 clocks, delayed by 5.
- Simultaneous: raw_i1=1, raw_i2=1 at the same edge, with raw_i1 dropping after 2 clocks -> i2 rises at edge 6; i1 never changes.
- Mid-operation reset: raw_i1 changes, rst asserted at edge 3 -> i1 stays RST_VAL; a fresh 6-edge latency applies after release.
- With SM_IN_COND_EDGE_EN: i1 0->1->0 transitions -> exactly one i1_rise and one i1_fall single-cycle pulse, coincident with the i1 level changes. No pulses appear before settled.

Source files
------------

// File: rtl/sm_in_cond_pkg.sv
// ============================================================================
// Module : sm_in_cond_pkg
// Brief  : Channel state encoding, channel count and the counter-width helper
//          shared by the sm_in_cond input conditioner.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package sm_in_cond_pkg;

  typedef enum logic {
    ST_STABLE   = 1'b0,
    ST_CHANGING = 1'b1
  } chan_state_t;

  localparam int N_CH = 2;

  // ceil(log2(value)), never less than 1 so a counter always has a bit
  function automatic int clog2_min1(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/sm_in_chan.sv
// ============================================================================
// Module : sm_in_chan
// Brief  : One conditioner channel: synchronizer chain, debounce FSM and,
//          with SM_IN_COND_EDGE_EN defined, rise/fall pulse outputs.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module sm_in_chan
  import sm_in_cond_pkg::*;
#(
  parameter int   SYNC_STAGES = 2,
  parameter int   DB_CYCLES   = 4,
  parameter logic RST_BIT     = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic out
`ifdef SM_IN_COND_EDGE_EN
  ,
  input  logic settled,
  output logic rise,
  output logic fall
`endif
);

  localparam int CNT_W = clog2_min1(DB_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync;
  logic                   syn;
  chan_state_t            state;
  logic [CNT_W-1:0]       cnt;

  assign syn = sync[SYNC_STAGES-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      sync  <= {SYNC_STAGES{RST_BIT}};
      out   <= RST_BIT;
      state <= ST_STABLE;
      cnt   <= '0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], raw};
      case (state)
        ST_STABLE: begin
          if (syn != out) begin
            if (DB_CYCLES == 1) begin
              out <= syn;
            end else begin
              cnt   <= CNT_W'(1);
              state <= ST_CHANGING;
            end
          end else begin
            cnt <= '0;
          end
        end
        ST_CHANGING: begin
          // Level fell back before the hold time ran out: treat as a glitch
          if (syn == out) begin
            cnt   <= '0;
            state <= ST_STABLE;
          end else if (cnt == CNT_LAST) begin
            out   <= ~out;
            cnt   <= '0;
            state <= ST_STABLE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: begin
          cnt   <= '0;
          state <= ST_STABLE;
        end
      endcase
    end
  end

`ifdef SM_IN_COND_EDGE_EN
  logic out_q;

  always_ff @(posedge clk) begin
    if (rst) out_q <= RST_BIT;
    else     out_q <= out;
  end

  // Pulses cover the first cycle the output shows its new level
  assign rise = settled & ~rst & out  & ~out_q;
  assign fall = settled & ~rst & ~out & out_q;
`endif

endmodule

`default_nettype wire

// File: rtl/sm_in_cond.sv
// ============================================================================
// Module : sm_in_cond
// Brief  : Two-channel synchronizer/debouncer with post-reset settled flag.
//          Optional edge pulses enabled by macro SM_IN_COND_EDGE_EN.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module sm_in_cond
  import sm_in_cond_pkg::*;
#(
  parameter int         SYNC_STAGES = 2,
  parameter int         DB_CYCLES   = 4,
  parameter logic [1:0] RST_VAL     = 2'b00
) (
  input  logic clk,
  input  logic rst,
  input  logic raw_i1,
  input  logic raw_i2,
  output logic i1,
  output logic i2,
  output logic settled
`ifdef SM_IN_COND_EDGE_EN
  ,
  output logic i1_rise,
  output logic i1_fall,
  output logic i2_rise,
  output logic i2_fall
`endif
);

  localparam int SETTLE_TOTAL = SYNC_STAGES + DB_CYCLES;
  localparam int SETTLE_W     = clog2_min1(SETTLE_TOTAL + 1);
  localparam logic [SETTLE_W-1:0] SETTLE_MAX  = SETTLE_W'(SETTLE_TOTAL);
  localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(SETTLE_TOTAL - 1);

  logic [N_CH-1:0] raw_v;
  logic [N_CH-1:0] out_v;
  logic [SETTLE_W-1:0] settle_cnt;

  assign raw_v = {raw_i2, raw_i1};
  assign i1    = out_v[0];
  assign i2    = out_v[1];

`ifdef SM_IN_COND_EDGE_EN
  logic [N_CH-1:0] rise_v;
  logic [N_CH-1:0] fall_v;

  assign i1_rise = rise_v[0];
  assign i1_fall = fall_v[0];
  assign i2_rise = rise_v[1];
  assign i2_fall = fall_v[1];
`endif

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    sm_in_chan #(
      .SYNC_STAGES (SYNC_STAGES),
      .DB_CYCLES   (DB_CYCLES),
      .RST_BIT     (RST_VAL[g])
    ) u_chan (
      .clk     (clk),
      .rst     (rst),
      .raw     (raw_v[g]),
      .out     (out_v[g])
`ifdef SM_IN_COND_EDGE_EN
      ,
      .settled (settled),
      .rise    (rise_v[g]),
      .fall    (fall_v[g])
`endif
    );
  end

  // Counter saturates so settled stays sticky until the next reset
  always_ff @(posedge clk) begin
    if (rst) begin
      settle_cnt <= '0;
      settled    <= 1'b0;
    end else begin
      if (settle_cnt != SETTLE_MAX) settle_cnt <= settle_cnt + SETTLE_W'(1);
      if (settle_cnt == SETTLE_LAST) settled <= 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_sm_in_cond.sv
// ============================================================================
// Module : tb_sm_in_cond
// Brief  : Directed self-checking bench for sm_in_cond at default parameters.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_sm_in_cond;

  logic clk = 1'b0;
  logic rst;
  logic raw_i1;
  logic raw_i2;
  logic i1;
  logic i2;
  logic settled;
`ifdef SM_IN_COND_EDGE_EN
  logic i1_rise, i1_fall, i2_rise, i2_fall;
`endif

  int checks   = 0;
  int failures = 0;

  always #10 clk = ~clk;

  sm_in_cond dut (
    .clk     (clk),
    .rst     (rst),
    .raw_i1  (raw_i1),
    .raw_i2  (raw_i2),
    .i1      (i1),
    .i2      (i2),
    .settled (settled)
`ifdef SM_IN_COND_EDGE_EN
    ,
    .i1_rise (i1_rise),
    .i1_fall (i1_fall),
    .i2_rise (i2_rise),
    .i2_fall (i2_fall)
`endif
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // Advance n rising edges; inputs change and outputs are sampled 1ns later
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    rst    = 1'b1;
    raw_i1 = 1'b1;
    raw_i2 = 1'b1;

    // Reset held two clocks with raw = 11
    step(1);
    check("rst1_i1", i1, 0);
    check("rst1_i2", i2, 0);
    check("rst1_settled", settled, 0);
    step(1);
    check("rst2_i1", i1, 0);
    check("rst2_settled", settled, 0);
    rst = 1'b0;
    step(5);
    check("post5_i1", i1, 0);
    check("post5_i2", i2, 0);
    check("post5_settled", settled, 0);
`ifdef SM_IN_COND_EDGE_EN
    check("post5_i1_rise", i1_rise, 0);
    check("post5_i2_rise", i2_rise, 0);
`endif
    step(1);
    check("post6_i1", i1, 1);
    check("post6_i2", i2, 1);
    check("post6_settled", settled, 1);
    raw_i1 = 1'b0;
    raw_i2 = 1'b0;
    step(10);
    check("idle_i1", i1, 0);
    check("idle_i2", i2, 0);

    // Clean step on channel 1
    raw_i1 = 1'b1;
    step(5);
    check("step_e5_i1", i1, 0);
    step(1);
    check("step_e6_i1", i1, 1);
    check("step_e6_i2", i2, 0);
`ifdef SM_IN_COND_EDGE_EN
    check("step_e6_rise", i1_rise, 1);
    check("step_e6_fall", i1_fall, 0);
    step(1);
    check("step_e7_rise", i1_rise, 0);
    step(3);
`else
    step(4);
`endif
    raw_i1 = 1'b0;
    step(5);
    check("stepdn_e5_i1", i1, 1);
`ifdef SM_IN_COND_EDGE_EN
    check("stepdn_e5_fall", i1_fall, 0);
`endif
    step(1);
    check("stepdn_e6_i1", i1, 0);
`ifdef SM_IN_COND_EDGE_EN
    check("stepdn_e6_fall", i1_fall, 1);
    step(1);
    check("stepdn_e7_fall", i1_fall, 0);
    check("stepdn_e7_rise", i1_rise, 0);
    step(3);
`else
    step(4);
`endif

    // Three-clock pulse on channel 2 is filtered out
    raw_i2 = 1'b1;
    step(3);
    raw_i2 = 1'b0;
    step(3);
    check("gl3_e6_i2", i2, 0);
    step(4);
    check("gl3_e10_i2", i2, 0);

    // Four-clock pulse on channel 2 passes, delayed by 5
    raw_i2 = 1'b1;
    step(4);
    raw_i2 = 1'b0;
    step(1);
    check("gl4_e5_i2", i2, 0);
    step(1);
    check("gl4_e6_i2", i2, 1);
    step(3);
    check("gl4_e9_i2", i2, 1);
    step(1);
    check("gl4_e10_i2", i2, 0);
    step(6);

    // Simultaneous change; channel 1 drops after two clocks
    raw_i1 = 1'b1;
    raw_i2 = 1'b1;
    step(2);
    raw_i1 = 1'b0;
    step(3);
    check("sim_e5_i2", i2, 0);
    step(1);
    check("sim_e6_i2", i2, 1);
    check("sim_e6_i1", i1, 0);
    step(6);
    check("sim_e12_i1", i1, 0);
    check("sim_e12_i2", i2, 1);
    raw_i2 = 1'b0;
    step(10);
    check("sim_end_i2", i2, 0);

    // Reset at edge 3 of a pending change on channel 1
    raw_i1 = 1'b1;
    step(2);
    rst = 1'b1;
    step(1);
    check("mid_rst_i1", i1, 0);
    check("mid_rst_settled", settled, 0);
    rst = 1'b0;
    step(5);
    check("mid_e5_i1", i1, 0);
    check("mid_e5_settled", settled, 0);
    step(1);
    check("mid_e6_i1", i1, 1);
    check("mid_e6_settled", settled, 1);
    check("mid_e6_i2", i2, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
